// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : ALU control codes shared by the ALU control decoder and EX stage
// Revision: 1.0
// ============================================================================
package alu_pkg;

   localparam int ALU_CTRL_W = 4;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctrl_e;

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// ============================================================================
// alu_exec_stage_if : ID/EX entry and EX/MEM exit handshake bundle
// Revision: 1.0
// ============================================================================
interface alu_exec_stage_if
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ALU_CTRL_W-1:0] alu_ctrl;
   logic [XLEN-1:0]       op_a;
   logic [XLEN-1:0]       op_b;
   logic [4:0]            rd_in;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       result;
   logic                  zero;
   logic                  ovf;
   logic                  illegal;
   logic [4:0]            rd_out;
   logic [CNT_W-1:0]      retired;

   modport slave (
      input  in_valid, alu_ctrl, op_a, op_b, rd_in, flush, out_ready,
      output in_ready, out_valid, result, zero, ovf, illegal, rd_out, retired
   );

   modport master (
      output in_valid, alu_ctrl, op_a, op_b, rd_in, flush, out_ready,
      input  in_ready, out_valid, result, zero, ovf, illegal, rd_out, retired
   );
endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational ALU datapath (AND/OR/ADD/SUB/SLT)
// Revision: 1.0
// ============================================================================
module alu_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic [ALU_CTRL_W-1:0] ctrl,
   input  wire logic [XLEN-1:0]       a,
   input  wire logic [XLEN-1:0]       b,
   output logic      [XLEN-1:0]       result,
   output logic                       ovf,
   output logic                       illegal
);
   logic [XLEN-1:0] w_sum;
   logic [XLEN-1:0] w_diff;
   logic            w_lt;

   assign w_sum  = a + b;
   assign w_diff = a - b;
   assign w_lt   = $signed(a) < $signed(b);

   always_comb begin
      result  = '0;
      ovf     = 1'b0;
      illegal = 1'b0;
      case (ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: begin
            result = w_sum;
            ovf    = (a[XLEN-1] == b[XLEN-1]) && (w_sum[XLEN-1] != a[XLEN-1]);
         end
         ALU_SUB: begin
            result = w_diff;
            ovf    = (a[XLEN-1] != b[XLEN-1]) && (w_diff[XLEN-1] != a[XLEN-1]);
         end
         ALU_SLT: result = {{(XLEN-1){1'b0}}, w_lt};
         default: illegal = 1'b1;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// alu_exec_stage : EX stage with valid/ready handshake, EX/MEM result register
//                  and retired-operation counter
// Revision: 1.0
// ============================================================================
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input wire logic        clk,
   input wire logic        rst_n,
   alu_exec_stage_if.slave bus
);
   logic [XLEN-1:0]  w_result;
   logic             w_ovf;
   logic             w_illegal;
   logic             w_capture;
   logic             w_consume;

   logic             r_valid;
   logic [XLEN-1:0]  r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_illegal;
   logic [4:0]       r_rd;
   logic [CNT_W-1:0] r_retired;

   alu_core #(.XLEN(XLEN)) u_core (
      .ctrl    (bus.alu_ctrl),
      .a       (bus.op_a),
      .b       (bus.op_b),
      .result  (w_result),
      .ovf     (w_ovf),
      .illegal (w_illegal)
   );

   assign bus.in_ready = !r_valid || bus.out_ready;
   assign w_capture    = bus.in_valid && bus.in_ready && !bus.flush;
   assign w_consume    = r_valid && bus.out_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_ovf     <= 1'b0;
         r_illegal <= 1'b0;
         r_rd      <= '0;
         r_retired <= '0;
      end else begin
         // flush wins over both a same-cycle capture and a consume
         if (bus.flush)
            r_valid <= 1'b0;
         else if (w_capture)
            r_valid <= 1'b1;
         else if (w_consume)
            r_valid <= 1'b0;

         if (w_capture) begin
            r_result  <= w_result;
            r_zero    <= (w_result == '0);
            r_ovf     <= w_ovf;
            r_illegal <= w_illegal;
            r_rd      <= bus.rd_in;
         end

         if (w_consume)
            r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.ovf       = r_ovf;
   assign bus.illegal   = r_illegal;
   assign bus.rd_out    = r_rd;
   assign bus.retired   = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_stage : directed-vector bench for alu_exec_stage
// Revision: 1.0
// ============================================================================
module tb_alu_exec_stage;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   alu_exec_stage_if #(.XLEN(32), .CNT_W(16)) bus  ();
   alu_exec_stage_if #(.XLEN(32), .CNT_W(4))  bus4 ();

   alu_exec_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   alu_exec_stage #(.XLEN(32), .CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic rdy);
      bus.in_valid  = v;
      bus.alu_ctrl  = c;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.rd_in     = rd;
      bus.out_ready = rdy;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0);
      bus.flush      = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.alu_ctrl  = ALU_ADD;
      bus4.op_a      = 32'h1;
      bus4.op_b      = 32'h2;
      bus4.rd_in     = 5'd1;
      bus4.flush     = 1'b0;
      bus4.out_ready = 1'b1;

      #3;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_result",    {32'd0, bus.result},    64'd0);
      chk("rst_retired",   {48'd0, bus.retired},   64'd0);
      chk("rst_rd_out",    {59'd0, bus.rd_out},    64'd0);
      step();
      step();
      rst_n = 1'b1;

      // ADD overflow
      drive(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
      step();
      chk("add_result",    {32'd0, bus.result},    64'h8000_0000);
      chk("add_ovf",       {63'd0, bus.ovf},       64'd1);
      chk("add_zero",      {63'd0, bus.zero},      64'd0);
      chk("add_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("add_rd_out",    {59'd0, bus.rd_out},    64'd3);

      // SUB to zero, replaces held result on simultaneous consume
      drive(1'b1, ALU_SUB, 32'h5, 32'h5, 5'd7, 1'b1);
      step();
      chk("sub_result",  {32'd0, bus.result},  64'd0);
      chk("sub_zero",    {63'd0, bus.zero},    64'd1);
      chk("sub_ovf",     {63'd0, bus.ovf},     64'd0);
      chk("sub_rd_out",  {59'd0, bus.rd_out},  64'd7);
      chk("sub_retired", {48'd0, bus.retired}, 64'd1);

      // signed SLT: -1 < 1
      drive(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd8, 1'b1);
      step();
      chk("slt_result",  {32'd0, bus.result},  64'd1);
      chk("slt_retired", {48'd0, bus.retired}, 64'd2);

      drive(1'b0, ALU_AND, 32'h0, 32'h0, 5'd0, 1'b1);
      step();
      chk("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("drain_retired",   {48'd0, bus.retired},   64'd3);

      // backpressure
      drive(1'b1, ALU_AND, 32'hF0F0, 32'hFF00, 5'd9, 1'b0);
      step();
      chk("bp_capture", {32'd0, bus.result}, 64'hF000);
      drive(1'b1, ALU_OR, 32'h1, 32'h2, 5'd4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
         step();
         chk("bp_result",    {32'd0, bus.result},    64'hF000);
         chk("bp_rd_out",    {59'd0, bus.rd_out},    64'd9);
         chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      end
      drive(1'b0, ALU_OR, 32'h1, 32'h2, 5'd4, 1'b1);
      #1;
      chk("bp_in_ready_rel", {63'd0, bus.in_ready}, 64'd1);
      step();
      chk("bp_out_valid_end", {63'd0, bus.out_valid}, 64'd0);
      chk("bp_not_taken",     {32'd0, bus.result},    64'hF000);
      chk("bp_retired",       {48'd0, bus.retired},   64'd4);

      // streaming: one result per cycle, retire starts on the second edge
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, ALU_ADD, 32'(k), 32'd100, 5'(k), 1'b1);
         step();
         chk("stream_result", {32'd0, bus.result},    64'(k + 100));
         chk("stream_valid",  {63'd0, bus.out_valid}, 64'd1);
      end
      chk("stream_retired", {48'd0, bus.retired}, 64'd13);

      // flush overrides consume and capture
      drive(1'b1, ALU_OR, 32'h3, 32'h4, 5'd5, 1'b1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("flush_retired",   {48'd0, bus.retired},   64'd13);
      chk("flush_result",    {32'd0, bus.result},    64'd110);

      // illegal code
      drive(1'b1, 4'b1111, 32'h5, 32'h3, 5'd2, 1'b0);
      step();
      chk("ill_illegal", {63'd0, bus.illegal}, 64'd1);
      chk("ill_result",  {32'd0, bus.result},  64'd0);
      chk("ill_zero",    {63'd0, bus.zero},    64'd1);
      chk("ill_ovf",     {63'd0, bus.ovf},     64'd0);

      // asynchronous reset in the middle of a stall
      drive(1'b1, ALU_AND, 32'hFFFF, 32'h00FF, 5'd6, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("arst_retired",   {48'd0, bus.retired},   64'd0);
      chk("arst_illegal",   {63'd0, bus.illegal},   64'd0);
      drive(1'b1, ALU_OR, 32'h10, 32'h01, 5'd11, 1'b0);
      step();
      chk("arst_no_capture", {63'd0, bus.out_valid}, 64'd0);
      rst_n = 1'b1;
      step();
      chk("arst_resume_valid",  {63'd0, bus.out_valid}, 64'd1);
      chk("arst_resume_result", {32'd0, bus.result},    64'h11);

      // 4-bit counter wraps 15 -> 0
      bus4.in_valid = 1'b1;
      for (int k = 1; k <= 16; k++) step();
      chk("wrap_15", {60'd0, bus4.retired}, 64'd15);
      step();
      chk("wrap_0",  {60'd0, bus4.retired}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter CNT_W, default 16, retired-operation counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  ID/EX entry presents an operation.
REQ-006 SHALL have port in_ready  output  1  stage accepts the operation this cycle.
REQ-007 SHALL have port alu_ctrl  input  4  ALU control code from the ALU control decoder.
REQ-008 SHALL have port op_a, op_b  input  XLEN  operands.
REQ-009 SHALL have port rd_in  input  5  destination register tag, passed through.
REQ-010 SHALL have port flush  input  1  discard the held result and any same-cycle input.
REQ-011 SHALL have port out_valid  output  1  EX/MEM register holds a result.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-013 SHALL have ports result  output  XLEN, zero  output  1, ovf  output  1, illegal  output  1, rd_out  output  5.
REQ-014 SHALL have port retired  output  CNT_W  count of results consumed downstream.

Function
REQ-015 SHALL decode alu_ctrl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0).
REQ-016 SHALL, for any other alu_ctrl, register result 0, illegal 1, ovf 0.
REQ-017 SHALL compute ADD/SUB modulo 2^XLEN; ovf = signed two's-complement overflow for ADD/SUB only, else 0.
REQ-018 SHALL set zero = (registered result == 0), including for illegal codes.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-020 SHALL capture an operation when in_valid && in_ready && !flush; result visible next cycle (latency 1).
REQ-021 SHALL clear out_valid after out_valid && out_ready when no new capture occurs the same cycle.
REQ-022 SHALL, on simultaneous consume and capture, replace the held result with the new one; out_valid stays 1.
REQ-023 SHALL hold result, flags and rd_out stable while out_valid && !out_ready.
REQ-024 SHALL, on flush, clear out_valid next cycle and not capture; flush overrides consume and capture.
REQ-025 SHALL increment retired by 1 per cycle with out_valid && out_ready && !flush; wraps from 2^CNT_W-1 to 0.
REQ-026 SHALL leave result/flag registers unchanged when no capture occurs (only out_valid gates meaning).

Reset
REQ-027 SHALL, on rst_n low, immediately clear out_valid, result, zero, ovf, illegal, rd_out, retired to 0.
REQ-028 SHALL drop any in-flight result on reset mid-operation; no capture while rst_n low.
REQ-029 SHALL resume normal capture on the first rising clk edge after rst_n deasserts.

Structure
REQ-030 SHALL take the ALU control code constants (AND/OR/ADD/SUB/SLT) from the shared package alu_pkg, also used by the ALU control decoder.
REQ-031 SHALL place the combinational datapath in one sub-module alu_core (ctrl, a, b -> result, ovf, illegal); alu_exec_stage owns handshake, register and counter.

Verification
REQ-032 SHALL test ADD 0x7FFFFFFF+1, out_ready=1 -> next cycle result 0x80000000, ovf 1, zero 0, out_valid 1.
REQ-033 SHALL test SUB 5-5, rd_in=7 -> result 0, zero 1, rd_out 7; SLT 0xFFFFFFFF,1 -> result 1.
REQ-034 SHALL test backpressure: capture AND 0xF0F0,0xFF00 with out_ready=0 for 3 cycles -> result 0xF000 held, in_ready 0, second in_valid not taken.
REQ-035 SHALL test streaming: in_valid and out_ready high 10 cycles -> 1 result/cycle, retired = 9 after 10 edges (first cycle no output).
REQ-036 SHALL test flush with out_valid=1, in_valid=1, out_ready=1 -> out_valid 0 next cycle, retired unchanged; alu_ctrl 1111 -> illegal 1, result 0.
REQ-037 SHALL test rst_n pulsed low mid-stall -> out_valid and retired 0 without a clock edge; CNT_W=4 wrap 15 -> 0.
